// File: rtl/mem_copy_master.sv
// mem_copy_master: bus-initiator engine on the picorv32 native memory interface.
// It accepts a single command and then copies LEN words from SRC to DST, or
// fills LEN words at DST with a constant. It checks that the addresses are
// word aligned, and a per-transaction watchdog guards every bus request.
// Every output comes straight from a register. Each register is loaded from
// the next-state value computed in one combinational block.
module mem_copy_master #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_fill,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    // The watchdog counts wait cycles 0..TIMEOUT-1. The request is abandoned
    // when one more cycle passes without ready while the count is at the top.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    state_t            after_r, after_s;
    logic              mode_r, mode_s;
    logic [31:0]       src_ptr_r, src_ptr_s;
    logic [31:0]       dst_ptr_r, dst_ptr_s;
    logic [LEN_W-1:0]  remain_r, remain_s;
    logic [31:0]       fill_r, fill_s;
    logic [31:0]       buf_r, buf_s;
    logic [LEN_W-1:0]  words_r, words_s;
    logic [WD_W-1:0]   wd_cnt_r, wd_cnt_s;
    logic              misalign_s;
    logic              err_s;

    logic              cmd_ready_r, busy_r, done_r, err_r, mem_valid_r;
    logic [31:0]       mem_addr_r, mem_wdata_r;
    logic [3:0]        mem_wstrb_r;
    logic              mem_valid_s;
    logic [31:0]       mem_addr_s, mem_wdata_s;
    logic [3:0]        mem_wstrb_s;

    // Next-state, datapath and watchdog decisions for the transfer sequencer
    always_comb begin
        state_s    = state_r;
        after_s    = after_r;
        mode_s     = mode_r;
        src_ptr_s  = src_ptr_r;
        dst_ptr_s  = dst_ptr_r;
        remain_s   = remain_r;
        fill_s     = fill_r;
        buf_s      = buf_r;
        words_s    = words_r;
        wd_cnt_s   = {WD_W{1'b0}};
        err_s      = 1'b0;
        misalign_s = (cmd_dst[1:0] != 2'b00) ||
                     ((cmd_mode == 1'b0) && (cmd_src[1:0] != 2'b00));
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_s    = cmd_mode;
                    src_ptr_s = cmd_src;
                    dst_ptr_s = cmd_dst;
                    remain_s  = cmd_len;
                    fill_s    = cmd_fill;
                    words_s   = {LEN_W{1'b0}};
                    if (misalign_s || (cmd_len == {LEN_W{1'b0}})) begin
                        // Nothing to move: report straight away, no bus activity
                        state_s = ST_FIN;
                        err_s   = misalign_s;
                    end else if (cmd_mode) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    buf_s     = mem_rdata;
                    src_ptr_s = src_ptr_r + 32'd4;
                    after_s   = ST_WR;
                    state_s   = ST_GAP;
                end else if (wd_cnt_r == WD_LAST) begin
                    state_s = ST_FIN;
                    err_s   = 1'b1;
                end else begin
                    wd_cnt_s = wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WR: begin
                if (mem_ready) begin
                    dst_ptr_s = dst_ptr_r + 32'd4;
                    words_s   = words_r + {{(LEN_W-1){1'b0}}, 1'b1};
                    remain_s  = remain_r - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (remain_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_s = ST_FIN;
                    end else begin
                        after_s = mode_r ? ST_WR : ST_RD;
                        state_s = ST_GAP;
                    end
                end else if (wd_cnt_r == WD_LAST) begin
                    state_s = ST_FIN;
                    err_s   = 1'b1;
                end else begin
                    wd_cnt_s = wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                state_s = after_r;
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus request fields for the state about to be entered; held while idle-on-bus
    always_comb begin
        mem_valid_s = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = 32'd0;
        mem_wstrb_s = 4'b0000;
        if (state_s == ST_RD) begin
            mem_valid_s = 1'b1;
            mem_addr_s  = src_ptr_s;
        end else if (state_s == ST_WR) begin
            mem_valid_s = 1'b1;
            mem_addr_s  = dst_ptr_s;
            mem_wdata_s = mode_s ? fill_s : buf_s;
            mem_wstrb_s = 4'b1111;
        end else begin
            mem_valid_s = 1'b0;
        end
    end

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            after_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            src_ptr_r   <= 32'd0;
            dst_ptr_r   <= 32'd0;
            remain_r    <= {LEN_W{1'b0}};
            fill_r      <= 32'd0;
            buf_r       <= 32'd0;
            words_r     <= {LEN_W{1'b0}};
            wd_cnt_r    <= {WD_W{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_wstrb_r <= 4'b0000;
        end else begin
            state_r     <= state_s;
            after_r     <= after_s;
            mode_r      <= mode_s;
            src_ptr_r   <= src_ptr_s;
            dst_ptr_r   <= dst_ptr_s;
            remain_r    <= remain_s;
            fill_r      <= fill_s;
            buf_r       <= buf_s;
            words_r     <= words_s;
            wd_cnt_r    <= wd_cnt_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
            err_r       <= (state_s == ST_FIN) ? err_s : 1'b0;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wstrb_r <= mem_wstrb_s;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign words_done = words_r;
    assign mem_valid  = mem_valid_r;
    assign mem_instr  = 1'b0;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master. The bench owns a behavioural memory
// responder whose ready latency can be changed for each command. A table of
// commands holds the expected result of each one. Further hand-written
// sequences cover transaction ordering, a command held during busy, and a
// reset that arrives in the middle of a transfer.
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_mode;
    logic [31:0] cmd_src, cmd_dst, cmd_fill;
    logic [15:0] cmd_len;
    logic        busy, done, err;
    logic [15:0] words_done;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    typedef struct {
        logic        mode;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic [31:0] fill;
        int          lat;
        logic        exp_err;
        int          exp_words;
        int          exp_cyc;
        int          exp_ntx;
        int          exp_run;
    } vec_t;

    logic [31:0] mem [bit [31:0]];
    tx_t         log_q[$];
    int          lat = 1;
    int          wcnt;

    mem_copy_master #(.LEN_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial contents: words 1..4 at 0x40..0x4C, an address-derived pattern elsewhere
    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (a >= 32'h40 && a < 32'h50) return ((a - 32'h40) >> 2) + 32'd1;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Responder: asserts ready after lat wait cycles (lat 0 = never), one-cycle pulse
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            wcnt = 0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
            wcnt = 0;
        end else if (mem_valid) begin
            if (lat != 0 && wcnt + 1 >= lat) begin
                mem_ready <= 1'b1;
                if (mem_wstrb == 4'hF) begin
                    mem[mem_addr] = mem_wdata;
                    log_q.push_back('{mem_wstrb, mem_addr, mem_wdata});
                end else begin
                    mem_rdata <= rd_mem(mem_addr);
                    log_q.push_back('{mem_wstrb, mem_addr, rd_mem(mem_addr)});
                end
            end else begin
                wcnt = wcnt + 1;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_mode = v.mode;
        cmd_src  = v.src;
        cmd_dst  = v.dst;
        cmd_len  = v.len;
        cmd_fill = v.fill;
    endtask

    // Issue one command, wait (bounded) for done, compare against the vector
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, run, maxrun, n0;
        bit got;
        lat = v.lat;
        @(negedge clk);
        drive_cmd(v);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n0 = log_q.size();
        cyc = 0; run = 0; maxrun = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (cyc == 1) begin
                check($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
                check($sformatf("v%0d_cmd_ready", idx), 64'(cmd_ready), 64'd0);
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL v%0d_done_wait: got no done expected done within 200 cycles", idx);
        end else begin
            check($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
            check($sformatf("v%0d_words", idx), 64'(words_done), 64'(v.exp_words));
            check($sformatf("v%0d_cycles", idx), 64'(cyc), 64'(v.exp_cyc));
            check($sformatf("v%0d_ntx", idx), 64'(log_q.size() - n0), 64'(v.exp_ntx));
            check($sformatf("v%0d_valid_run", idx), 64'(maxrun), 64'(v.exp_run));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
            check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
            check($sformatf("v%0d_idle_ready", idx), 64'(cmd_ready), 64'd1);
        end
    endtask

    // Wait (bounded) for done; returns the number of cycles waited or -1
    task automatic wait_done(output int cyc);
        bit got;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_done: got no done expected done within 200 cycles");
            cyc = -1;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int cyc, n0;
        vec_t v;

        //            mode  src           dst           len    fill          lat err words cyc ntx run
        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0000_0080, 16'd4, 32'h0,         1, 1'b0, 4, 24, 8, 2};
        vecs[1] = '{1'b1, 32'h0,         32'h0000_0100, 16'd3, 32'hDEAD_BEEF, 1, 1'b0, 3,  9, 3, 2};
        vecs[2] = '{1'b0, 32'h0,         32'h0,         16'd0, 32'h0,         1, 1'b0, 0,  1, 0, 0};
        vecs[3] = '{1'b1, 32'h0,         32'h0000_0102, 16'd2, 32'h1,         1, 1'b1, 0,  1, 0, 0};
        vecs[4] = '{1'b0, 32'h0000_0041, 32'h0000_0080, 16'd1, 32'h0,         1, 1'b1, 0,  1, 0, 0};
        vecs[5] = '{1'b1, 32'h0,         32'h0000_0102, 16'd0, 32'h0,         1, 1'b1, 0,  1, 0, 0};
        vecs[6] = '{1'b1, 32'h0000_0003, 32'h0000_0200, 16'd1, 32'h1234_5678, 1, 1'b0, 1,  3, 1, 2};
        vecs[7] = '{1'b1, 32'h0,         32'hFFFF_FFFC, 16'd2, 32'hA5A5_A5A5, 1, 1'b0, 2,  6, 2, 2};
        vecs[8] = '{1'b1, 32'h0,         32'h0000_0300, 16'd2, 32'h7777_7777, 0, 1'b1, 0,  9, 0, 8};
        vecs[9] = '{1'b1, 32'h0,         32'h0000_0300, 16'd2, 32'h6666_6666, 7, 1'b0, 2, 18, 2, 8};

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_mode = 1'b0;
        cmd_src = 32'd0; cmd_dst = 32'd0; cmd_len = 16'd0; cmd_fill = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_words", 64'(words_done), 64'd0);
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_instr", 64'(mem_instr), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_wstrb", 64'(mem_wstrb), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Copy ordering: R,W,R,W... with the read data forwarded to each write
        for (int i = 0; i < 8; i++) begin
            check($sformatf("copy_tx%0d_strb", i), 64'(log_q[i].strb), (i % 2) ? 64'hF : 64'h0);
            check($sformatf("copy_tx%0d_addr", i), 64'(log_q[i].addr),
                  (i % 2) ? 64'(32'h80 + 32'(4 * (i / 2))) : 64'(32'h40 + 32'(4 * (i / 2))));
            check($sformatf("copy_tx%0d_data", i), 64'(log_q[i].data), 64'(i / 2 + 1));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("copy_mem%0d", i), 64'(rd_mem(32'h80 + 32'(4 * i))), 64'(i + 1));
        // Fill transactions and wrap-around destinations
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fill_tx%0d_addr", i), 64'(log_q[8 + i].addr), 64'(32'h100 + 32'(4 * i)));
            check($sformatf("fill_tx%0d_data", i), 64'(log_q[8 + i].data), 64'hDEAD_BEEF);
            check($sformatf("fill_tx%0d_strb", i), 64'(log_q[8 + i].strb), 64'hF);
        end
        check("wrap_mem_top", 64'(rd_mem(32'hFFFF_FFFC)), 64'hA5A5_A5A5);
        check("wrap_mem_zero", 64'(rd_mem(32'h0000_0000)), 64'hA5A5_A5A5);
        check("race_mem0", 64'(rd_mem(32'h300)), 64'h6666_6666);
        check("race_mem1", 64'(rd_mem(32'h304)), 64'h6666_6666);

        // cmd_valid held high through a busy copy: the second command waits for done
        lat = 1;
        n0 = log_q.size();
        @(negedge clk);
        v = '{1'b0, 32'h40, 32'h600, 16'd2, 32'h0, 1, 1'b0, 2, 12, 4, 2};
        drive_cmd(v);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        v = '{1'b1, 32'h0, 32'h700, 16'd1, 32'h55, 1, 1'b0, 1, 3, 1, 2};
        drive_cmd(v);
        wait_done(cyc);
        check("hold_first_cycles", 64'(cyc), 64'd12);
        check("hold_first_words", 64'(words_done), 64'd2);
        check("hold_first_ntx", 64'(log_q.size() - n0), 64'd4);
        @(negedge clk);
        check("hold_idle_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(cyc);
        check("hold_second_cycles", 64'(cyc), 64'd3);
        check("hold_second_words", 64'(words_done), 64'd1);
        check("hold_second_err", 64'(err), 64'd0);
        check("hold_mem600", 64'(rd_mem(32'h600)), 64'd1);
        check("hold_mem604", 64'(rd_mem(32'h604)), 64'd2);
        check("hold_mem700", 64'(rd_mem(32'h700)), 64'h55);

        // Reset in the middle of a write: outputs drop without waiting for a clock
        @(negedge clk);
        v = '{1'b1, 32'h0, 32'h800, 16'd4, 32'h99, 1, 1'b0, 0, 0, 0, 0};
        drive_cmd(v);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_wr_valid", 64'(mem_valid), 64'd1);
        check("mid_wr_strb", 64'(mem_wstrb), 64'hF);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 64'(mem_valid), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rel_ready", 64'(cmd_ready), 64'd1);
        check("rst_rel_done", 64'(done), 64'd0);
        check("rst_rel_words", 64'(words_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus-initiator engine on the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Accepts a one-shot command, then either copies LEN words from SRC to DST or fills LEN words at DST with a constant.
- Drives the same slave memory/MMIO responders the core uses; lets benches and SoC glue move data without the CPU.
- Includes alignment checking and a per-transaction watchdog.

Parameters:
- LEN_W, 16, width of the word-count fields.
- TIMEOUT, 256, cycles mem_valid may stay high without mem_ready before the command aborts; must be ≥1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on a cmd_valid & cmd_ready edge.
- cmd_mode  in  1  0 = copy, 1 = fill.
- cmd_src  in  32  source byte address (copy only).
- cmd_dst  in  32  destination byte address.
- cmd_len  in  LEN_W  number of 32-bit words.
- cmd_fill  in  32  fill data (fill only).
- busy  out  1  high from the accept edge until return to IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done: 1 = misaligned address or timeout.
- words_done  out  LEN_W  words written so far; holds its final value until the next accept.
- mem_valid  out  1  bus request.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder completion; one-cycle pulse.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  0000 = read, 1111 = write.
- mem_rdata  in  32  read data, sampled in the mem_ready cycle.

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; all other outputs, pointers, counters and the data buffer 0.
- States: IDLE, RD, WR, GAP, FIN.
- IDLE, on accept:
  - Latch mode, src, dst, len, fill. Clear words_done.
  - len==0, or cmd_dst[1:0]≠0, or (copy and cmd_src[1:0]≠0) → FIN; no bus activity.
  - err=1 only for the misalignment cases; len==0 with aligned addresses gives err=0.
  - Otherwise → RD (copy) or WR (fill).
- RD:
  - mem_valid=1, mem_addr=src_ptr, mem_wstrb=0000, mem_wdata=0.
  - On mem_ready: buf←mem_rdata, src_ptr+=4, → GAP (next=WR).
- WR:
  - mem_valid=1, mem_addr=dst_ptr, mem_wdata=buf (copy) or fill, mem_wstrb=1111.
  - On mem_ready: dst_ptr+=4, words_done+=1, remaining-=1.
  - If remaining reaches 0 → FIN; else → GAP (next=RD for copy, WR for fill).
- GAP: exactly one cycle with mem_valid=0, then the next state. Guarantees a deasserted cycle between transactions for registered-ready responders.
- FIN: done=1 for one cycle, err as determined, then → IDLE; busy=0 and cmd_ready=1 on the following cycle.
- Bus stability: mem_addr, mem_wdata and mem_wstrb are registered and constant while mem_valid=1. mem_valid drops in the cycle after the mem_ready cycle.
- Pointers wrap modulo 2^32 (0xFFFFFFFC+4 → 0x00000000); no error is raised on wrap.
- Watchdog:
  - Counter clears on entry to RD/WR and increments each cycle mem_valid=1 without mem_ready.
  - At count==TIMEOUT: mem_valid→0 the next cycle, → FIN with err=1. words_done reflects only completed writes.
  - mem_ready arriving in the same cycle the count hits TIMEOUT wins; the transaction completes normally.
- mem_ready while mem_valid=0 is ignored.
- cmd_valid while busy is ignored; there is no queueing.
- Reset mid-transfer drops mem_valid immediately (async) and returns to IDLE with no done pulse.
- Throughput with a 1-cycle registered-ready responder:
  - Copy: 6 cycles/word (RD 2, GAP 1, WR 2, GAP 1).
  - Fill: 3 cycles/word.

Test Plan:
- Copy: memory[0x40..0x4C]={1,2,3,4}, cmd src=0x40, dst=0x80, len=4 → memory[0x80..0x8C]={1,2,3,4}; 4 reads then 4 writes interleaved R,W,R,W…; words_done=4; single done with err=0; 24 cycles accept→done at 1-cycle ready.
- Fill: dst=0x100, len=3, fill=0xDEADBEEF → three writes at 0x100/0x104/0x108, wstrb=1111; mem_valid low one cycle between them; done, err=0, words_done=3.
- Boundaries:
  - len=0 → done one cycle after FIN entry, err=0, no mem_valid.
  - dst=0x102 → done, err=1, no mem_valid.
  - Fill dst=0xFFFFFFFC, len=2 → writes at 0xFFFFFFFC, 0x00000000.
- Timeout: TIMEOUT=8, responder never asserts ready → mem_valid high exactly 8 cycles then low; done with err=1; words_done=0.
- Timeout race: TIMEOUT=8 with ready at the 8th wait cycle → transaction completes and the transfer continues; err=0 at the end.
- Protocol/reset:
  - cmd_valid held high during a busy copy → ignored; second command accepted only after done.
  - reset asserted mid-WR → mem_valid, busy, done low immediately; cmd_ready=1 after release.
